// File: rtl/led_sequencer_if.sv
// led_sequencer_if: APB3 bus bundle between a requester and the LED sequencer
// Signals: PSEL/PENABLE/PWRITE/PADDR/PWDATA from the requester,
//          PRDATA/PREADY/PSLVERR back from the peripheral
interface led_sequencer_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY, PSLVERR);
    modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/led_sequencer.sv
// led_sequencer: APB3 slave playing up to 8 timed 24-bit patterns on the LED bank
// Ports: PCLK clock, PRESERN async active-low reset, apb APB3 slave bundle,
//        LED registered 24-bit drive (1 = on)
module led_sequencer (
    input  logic           PCLK,
    input  logic           PRESERN,
    led_sequencer_if.slave apb,
    output logic [23:0]    LED
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [23:0] cnt_q, cnt_d;
    logic [23:0] led_q, led_d;
    logic        en_q, en_d;
    logic        oneshot_q;
    logic [2:0]  last_q;
    logic [23:0] period_q, manual_q, per_m1, manual_d, pat_shown_d;
    logic [23:0] pat_q [8];
    logic [31:0] prdata_q, rdata;
    logic [7:0]  off;
    logic [2:0]  pat_idx;
    logic        sel_pat, mapped, wr, wr_ctrl;

    assign off     = apb.PADDR[7:0];
    assign pat_idx = off[4:2];
    assign sel_pat = off[7:5] == 3'b001 && off[1:0] == 2'b00;
    assign mapped  = sel_pat || off == 8'h00 || off == 8'h04 || off == 8'h08 || off == 8'h0C;
    assign wr      = apb.PSEL && apb.PENABLE && apb.PWRITE;
    assign wr_ctrl = wr && off == 8'h00;
    assign per_m1  = period_q == 24'd0 ? 24'd0 : period_q - 24'd1;

    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = apb.PSEL && apb.PENABLE && !mapped;
    assign apb.PRDATA  = prdata_q;
    assign LED         = led_q;

    always_comb begin
        rdata = sel_pat        ? {8'h0, pat_q[pat_idx]} :
                off == 8'h00   ? {27'h0, last_q, oneshot_q, en_q} :
                off == 8'h04   ? {8'h0, period_q} :
                off == 8'h08   ? {25'h0, idx_q, 2'b00, state_q == DONE, state_q == RUN} :
                off == 8'h0C   ? {8'h0, manual_q} : 32'h0;
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
        end
    end

    // A CTRL write overrides any sequencer step, so software always wins over the hardware stop.
    // ">=" lets a PERIOD shrunk below cnt advance on the next compare; "idx >= LAST" honours a lowered LAST.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (wr_ctrl) begin
            state_d = apb.PWDATA[0] ? RUN : IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            if (cnt_q >= per_m1) begin
                cnt_d = '0;
                if (idx_q < last_q) idx_d = idx_q + 3'd1;
                else if (!oneshot_q) idx_d = '0;
                else begin
                    state_d = DONE;
                    idx_d   = last_q;
                end
            end else cnt_d = cnt_q + 24'd1;
        end
    end

    // LED is computed from next-state values so a register write shows on its own commit edge.
    always_comb begin
        manual_d    = wr && off == 8'h0C ? apb.PWDATA[23:0] : manual_q;
        pat_shown_d = wr && sel_pat && pat_idx == idx_d ? apb.PWDATA[23:0] : pat_q[idx_d];
        led_d       = state_d == IDLE ? manual_d : pat_shown_d;
        en_d        = wr_ctrl ? apb.PWDATA[0] : state_q == RUN && state_d == DONE ? 1'b0 : en_q;
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            en_q      <= 1'b0;
            oneshot_q <= 1'b0;
            last_q    <= '0;
            period_q  <= '0;
            manual_q  <= '0;
            pat_q     <= '{default: '0};
            prdata_q  <= '0;
        end else begin
            en_q <= en_d;
            if (wr_ctrl) begin
                oneshot_q <= apb.PWDATA[1];
                last_q    <= apb.PWDATA[4:2];
            end
            if (wr && off == 8'h04) period_q <= apb.PWDATA[23:0];
            if (wr && off == 8'h0C) manual_q <= apb.PWDATA[23:0];
            if (wr && sel_pat) pat_q[pat_idx] <= apb.PWDATA[23:0];
            if (apb.PSEL && !apb.PENABLE) prdata_q <= rdata;
        end
    end
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed scoreboard bench for the APB LED sequencer
module tb_led_sequencer;
    logic        PCLK = 1'b0;
    logic        PRESERN = 1'b0;
    logic [23:0] LED;
    led_sequencer_if apb();
    led_sequencer dut (.PCLK(PCLK), .PRESERN(PRESERN), .apb(apb.slave), .LED(LED));

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_err = 0;
    logic [31:0] exp_q [$];
    logic [23:0] pat [3] = '{24'h000001, 24'h000002, 24'h000004};

    task automatic push(input logic [31:0] e);
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag, input logic [31:0] act);
        logic [31:0] e;
        n_checks++;
        e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hDEAD_BEEF;
        assert (act === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, act, e);
        end
    endtask

    task automatic apb_write(input logic [7:0] off, input logic [31:0] d, output logic err);
        @(posedge PCLK); #1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
        apb.PADDR = {24'h0, off}; apb.PWDATA = d;
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        @(negedge PCLK);
        err = apb.PSLVERR;
        @(posedge PCLK); #1;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] off, output logic [31:0] d, output logic err);
        @(posedge PCLK); #1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = {24'h0, off};
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        @(negedge PCLK);
        d = apb.PRDATA;
        err = apb.PSLVERR;
        @(posedge PCLK); #1;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        logic e;
        apb_write(off, d, e);
    endtask

    task automatic rd_check(input string tag, input logic [7:0] off, input logic [31:0] e);
        logic [31:0] d;
        logic err;
        apb_read(off, d, err);
        push(e);
        check(tag, d);
    endtask

    initial begin
        logic [31:0] d;
        logic err;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = '0; apb.PWDATA = '0;
        #12;
        push(32'h0); check("reset_led", {8'h0, LED});
        push(32'h0); check("reset_prdata", apb.PRDATA);
        @(negedge PCLK); PRESERN = 1'b1;

        apb_write(8'h0C, 32'h00A5A5A5, err);
        push(32'h00A5A5A5); check("manual_led", {8'h0, LED});
        push(32'h0); check("manual_pslverr", {31'h0, err});

        wr(8'h20, 32'h1); wr(8'h24, 32'h2); wr(8'h28, 32'h4);
        wr(8'h04, 32'd3);
        wr(8'h00, 32'h9);
        for (int k = 0; k < 12; k++) begin
            push({8'h0, pat[(k / 3) % 3]});
            @(negedge PCLK);
            check("loop_led", {8'h0, LED});
        end
        apb_read(8'h08, d, err);
        push(32'h1); check("loop_busy", d & 32'h3);

        wr(8'h00, 32'hB);
        for (int k = 0; k < 12; k++) begin
            push({8'h0, k < 9 ? pat[k / 3] : 24'h000004});
            @(negedge PCLK);
            check("oneshot_led", {8'h0, LED});
        end
        rd_check("oneshot_status", 8'h08, 32'h22);
        rd_check("oneshot_ctrl", 8'h00, 32'h0A);
        wr(8'h00, 32'h0);
        push(32'h00A5A5A5); check("stop_manual", {8'h0, LED});

        wr(8'h04, 32'd0);
        wr(8'h00, 32'h9);
        for (int k = 0; k < 6; k++) begin
            push({8'h0, pat[k % 3]});
            @(negedge PCLK);
            check("period0_led", {8'h0, LED});
        end
        wr(8'h00, 32'h9);
        push(32'h1); check("restart_led", {8'h0, LED});
        push(32'h1); @(negedge PCLK); check("restart_hold", {8'h0, LED});
        push(32'h2); @(negedge PCLK); check("restart_next", {8'h0, LED});

        apb_read(8'h10, d, err);
        push(32'h0); check("err_rdata", d);
        push(32'h1); check("err_rd_pslverr", {31'h0, err});
        apb_write(8'h10, 32'hFFFF_FFFF, err);
        push(32'h1); check("err_wr_pslverr", {31'h0, err});
        rd_check("err_period_kept", 8'h04, 32'h0);
        rd_check("err_manual_kept", 8'h0C, 32'h00A5A5A5);
        apb_write(8'h08, 32'hFFFF_FFFF, err);
        push(32'h0); check("status_wr_pslverr", {31'h0, err});

        #3 PRESERN = 1'b0;
        #1;
        push(32'h0); check("async_reset_led", {8'h0, LED});
        repeat (2) @(negedge PCLK);
        PRESERN = 1'b1;
        rd_check("rst_ctrl", 8'h00, 32'h0);
        rd_check("rst_period", 8'h04, 32'h0);
        rd_check("rst_status", 8'h08, 32'h0);
        rd_check("rst_manual", 8'h0C, 32'h0);
        rd_check("rst_pat0", 8'h20, 32'h0);
        rd_check("rst_pat2", 8'h28, 32'h0);
        push(32'h0); check("rst_led_after", {8'h0, LED});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
